fm_audio_decimator: RTL
=======================

FM_AUDIO_DECIMATOR -- requirements
Module: fm_audio_decimator

Interface
REQ-001 Parameter: C_S00_AXIS_TDATA_WIDTH, 32, input stream data width.
REQ-002 Parameter: C_M00_AXIS_TDATA_WIDTH, 32, output stream data width.
REQ-003 Parameter: DECIM, 8, decimation ratio; power of two, 2..256; LOG2_DECIM derived internally.
REQ-004 Parameter: DEEMPH_SHIFT, 4, de-emphasis coefficient as a right shift, 1..8; used only when FM_DEEMPH_EN is defined.
REQ-005 Port: s00_axis_aclk  in  1  single clock for all logic.
REQ-006 Port: s00_axis_areset  in  1  reset; synchronous, active-high.
REQ-007 Port: s00_axis_tvalid  in  1  input beat valid.
REQ-008 Port: s00_axis_tdata  in  32  [15:0] is signed frequency sample (demodulator angle difference); [31:16] ignored.
REQ-009 Port: s00_axis_tlast  in  1  end of packet; flushes the current group.
REQ-010 Port: s00_axis_tstrb  in  4  ignored.
REQ-011 Port: s00_axis_tready  out  1  input accept.
REQ-012 Port: m00_axis_tready  in  1  downstream accept.
REQ-013 Port: m00_axis_tvalid  out  1  output beat valid.
REQ-014 Port: m00_axis_tdata  out  32  [15:0] signed audio sample; [31:16] zero.
REQ-015 Port: m00_axis_tlast  out  1  set on the output beat produced by a tlast flush.
REQ-016 Port: m00_axis_tstrb  out  4  constant 4'hF while tvalid is high.

Function
REQ-017 s00_axis_tready SHALL equal !m00_axis_tvalid || m00_axis_tready; a beat is accepted when tvalid && tready.
REQ-018 Each accepted sample SHALL be sign-extended and added to an accumulator 16+LOG2_DECIM bits wide, so the accumulator never overflows.
REQ-019 A group count SHALL run 0..DECIM-1 and advance by one per accepted beat.
REQ-020 Dump occurs on the accepted beat where count == DECIM-1 or tlast == 1.
REQ-021 On dump, avg = (acc + sample) >>> LOG2_DECIM (arithmetic shift, floor toward minus infinity), truncated to 16 bits.
REQ-022 On dump, the accumulator and count SHALL clear in the same cycle.
REQ-023 A tlast flush of a partial group SHALL use the same shift; the partial sum is not renormalised.
REQ-024 On dump, m00_axis_tdata, tlast and tstrb SHALL register, and m00_axis_tvalid SHALL assert the next cycle; latency is 1 cycle from the last accepted beat.
REQ-025 Non-dump accepted beats SHALL leave m00_axis_* unchanged.
REQ-026 m00_axis_tvalid SHALL clear after a cycle with tvalid && m00_axis_tready and no new dump.
REQ-027 A dump concurrent with the output being taken SHALL reload the output and keep tvalid high.
REQ-028 While tvalid && !m00_axis_tready, all m00_axis_* outputs SHALL hold stable; no sample is lost or duplicated.
REQ-029 Two FSM states: ACCUM (count < DECIM-1, no pending output) and HOLD (output valid, awaiting tready); the state equals m00_axis_tvalid.

Reset
REQ-030 Reset SHALL clear: m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tlast=0, m00_axis_tstrb=0, accumulator=0, count=0, de-emphasis state=0.
REQ-031 Reset mid-group SHALL discard the partial sum; the first group after reset spans DECIM fresh beats.

Configuration
REQ-032 Macro FM_DEEMPH_EN defined: on dump, y_next = y + ((avg - y) >>> DEEMPH_SHIFT), with the difference computed in 17 bits.
REQ-033 With FM_DEEMPH_EN defined, y_next is registered into the state y and output instead of avg; latency is unchanged; y persists across tlast.
REQ-034 Macro FM_DEEMPH_EN undefined: avg is output directly and no de-emphasis logic exists.

Structure
REQ-035 Package fm_audio_pkg SHALL hold: typedef logic signed [15:0] audio_sample_t, constant AUDIO_W=16, and the function computing LOG2_DECIM.
REQ-036 De-emphasis SHALL be a sub-module fm_deemph_iir (enable, avg in, y_next out, state register), instantiated only under FM_DEEMPH_EN.

Verification
REQ-037 DECIM=4, inputs 100,200,300,400, tready=1 -> one output of 250, tvalid high one cycle after the 4th accept, tlast=0.
REQ-038 DECIM=4, inputs -3,-3,-3,-2 -> output -3 (floor of -2.75).
REQ-039 Output valid with m00_axis_tready=0 for 5 cycles -> s00_axis_tready=0 and m00_axis_tdata stable; after release the next group is exact.
REQ-040 DECIM=4, inputs 40,40 with tlast on the 2nd -> output 20 with tlast=1; the next group starts at count 0.
REQ-041 Reset asserted after 2 of 4 samples -> all outputs 0; the next 4 samples of 8 each -> output 8.
REQ-042 FM_DEEMPH_EN, DECIM=4, DEEMPH_SHIFT=2, constant input 400 -> outputs 100, 175, 231.

Source files
------------

// File: rtl/fm_audio_pkg.sv
// ---------------------------------------------------------------------------
// fm_audio_pkg
// Shared types and helpers for the FM audio decimation path.
//   audio_sample_t : signed 16-bit audio / frequency sample
//   AUDIO_W        : width of audio_sample_t
//   state_t        : decimator FSM state (ACCUM collecting, HOLD output pending)
//   log2_decim()   : log2 of a power-of-two decimation ratio (2..256)
// ---------------------------------------------------------------------------
package fm_audio_pkg;

    localparam int AUDIO_W = 16;

    typedef logic signed [15:0] audio_sample_t;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Loop is bounded so it elaborates to a constant for any legal ratio.
    function automatic int log2_decim(input int decim);
        int result;
        result = 0;
        for (int i = 0; i <= 8; i++) begin
            if ((1 << i) == decim) begin
                result = i;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fm_deemph_iir.sv
// ---------------------------------------------------------------------------
// fm_deemph_iir
// First-order de-emphasis filter: y_next = y + ((avg - y) >>> DEEMPH_SHIFT).
// The state y is updated only when enable is high (one update per output).
// Ports:
//   clk     : clock
//   reset   : synchronous active-high reset, clears y
//   enable  : load y_next into y this cycle
//   avg     : decimated input sample
//   y_next  : filter output for the current avg (combinational)
// ---------------------------------------------------------------------------
module fm_deemph_iir
    import fm_audio_pkg::*;
#(
    parameter int DEEMPH_SHIFT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  audio_sample_t avg,
    output audio_sample_t y_next
);

    audio_sample_t            y;
    logic signed [AUDIO_W:0]  diff;
    logic signed [AUDIO_W:0]  step;
    logic signed [AUDIO_W:0]  sum_ext;

    // The difference needs 17 bits; y + step always lies between y and avg,
    // so the final result fits back into 16 bits without saturation.
    always_comb begin
        diff    = {avg[AUDIO_W-1], avg} - {y[AUDIO_W-1], y};
        step    = diff >>> DEEMPH_SHIFT;
        sum_ext = {y[AUDIO_W-1], y} + step;
        y_next  = sum_ext[AUDIO_W-1:0];
    end

    // Filter state persists across packet boundaries; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            y <= '0;
        end else if (enable) begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/fm_audio_decimator.sv
// ---------------------------------------------------------------------------
// fm_audio_decimator
// Averages groups of DECIM signed frequency samples from an AXI-Stream input
// into one audio sample on an AXI-Stream output. A tlast beat flushes the
// current (possibly partial) group using the same shift.
// Optional macro FM_DEEMPH_EN inserts a first-order de-emphasis filter
// (fm_deemph_iir) after the averaging stage.
// Ports:
//   s00_axis_aclk    : clock
//   s00_axis_areset  : synchronous active-high reset
//   s00_axis_tvalid/tready/tdata/tlast/tstrb : input stream, tdata[15:0] used
//   m00_axis_tvalid/tready/tdata/tlast/tstrb : output stream, tdata[15:0]
//                      signed audio, upper bits zero, tstrb 4'hF when valid
// ---------------------------------------------------------------------------
module fm_audio_decimator
    import fm_audio_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int DECIM                  = 8,
    parameter int DEEMPH_SHIFT           = 4
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_areset,
    input  logic                                s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                                s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    output logic                                s00_axis_tready,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

    localparam int LOG2_DECIM = log2_decim(DECIM);
    localparam int ACC_W      = AUDIO_W + LOG2_DECIM;
    localparam logic [LOG2_DECIM-1:0] LAST_COUNT = LOG2_DECIM'(DECIM - 1);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sum_shifted;
    logic [LOG2_DECIM-1:0]   count;
    audio_sample_t           sample;
    audio_sample_t           avg;
    audio_sample_t           out_sample;
    logic [AUDIO_W-1:0]      out_bits;
    logic                    accept;
    logic                    dump;

    // Upper tdata bits and tstrb carry no information for this block.
    logic unused_inputs;
    assign unused_inputs = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:AUDIO_W]};

    // The input may advance whenever the output register is empty or is being
    // drained this cycle, so a dump can never overwrite an untaken result.
    assign s00_axis_tready = (state == ACCUM) || m00_axis_tready;
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign dump            = accept && ((count == LAST_COUNT) || s00_axis_tlast);

    // Accumulator is wide enough for DECIM full-scale samples. The shift is
    // arithmetic on a signed value, giving floor rounding; a partial tlast
    // group is deliberately not renormalised.
    always_comb begin
        sample      = s00_axis_tdata[AUDIO_W-1:0];
        sum         = acc + {{LOG2_DECIM{sample[AUDIO_W-1]}}, sample};
        sum_shifted = sum >>> LOG2_DECIM;
        avg         = sum_shifted[AUDIO_W-1:0];
    end

`ifdef FM_DEEMPH_EN
    audio_sample_t y_next;

    fm_deemph_iir #(
        .DEEMPH_SHIFT(DEEMPH_SHIFT)
    ) u_deemph (
        .clk    (s00_axis_aclk),
        .reset  (s00_axis_areset),
        .enable (dump),
        .avg    (avg),
        .y_next (y_next)
    );

    assign out_sample = y_next;
`else
    localparam int unused_deemph_shift = DEEMPH_SHIFT;

    assign out_sample = avg;
`endif

    assign out_bits = out_sample;

    // Group accumulation: clears on the dumping beat so the next accepted beat
    // starts a fresh group at count 0.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            if (dump) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= sum;
                count <= count + 1'b1;
            end
        end
    end

    // Output FSM: HOLD mirrors m00_axis_tvalid. A dump always reloads the
    // output (including when the previous result is being taken this cycle);
    // otherwise a taken output returns the FSM to ACCUM.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state           <= ACCUM;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tstrb  <= '0;
        end else if (dump) begin
            state           <= HOLD;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'(out_bits);
            m00_axis_tlast  <= s00_axis_tlast;
            m00_axis_tstrb  <= '1;
        end else if (m00_axis_tvalid && m00_axis_tready) begin
            state           <= ACCUM;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tstrb  <= '0;
        end
    end

endmodule
